// File: rtl/seu_emr_unloader.sv
// rtl/seu_emr_unloader.sv - CRC/EMR atom shift sequencer with capture cache FIFO
//
// On every rising edge of the atom's crcerror this block asks the atom to
// parallel-load its Error Message Register. It then shifts emr_reg_width bits
// out of regout, assembles them LSB-first into a word and pushes that word into
// a small circular cache. An external processor drains the cache with the
// emr_cache_int / emr_cache_ack handshake.
//
// Optional build macro: SEU_EMR_DUP_FILTER_EN
//   When defined, a completed capture that equals the last word successfully
//   pushed is discarded instead of being stored again.
//
// Ports:
//   clk              in   single clock shared with the atom
//   reset            in   asynchronous, active-high reset
//   crcerror         in   crcerror output of the atom
//   regout           in   serial EMR data from the atom
//   shiftnld         out  to the atom: 0 = parallel load, 1 = shift
//   emr_data         out  cache head entry, valid while emr_cache_int = 1
//   emr_cache_int    out  cache not empty
//   emr_cache_ack    in   pops the head entry
//   cache_fill_level out  current cache occupancy
//   cache_full       out  occupancy == cache_depth
//   overflow         out  sticky: a capture was lost
//   busy             out  capture sequencer not idle

module seu_emr_unloader #(
  parameter  int emr_reg_width = 46,
  parameter  int cache_depth   = 4,
  localparam int LEVEL_W       = $clog2(cache_depth + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     crcerror,
  input  logic                     regout,
  output logic                     shiftnld,
  output logic [emr_reg_width-1:0] emr_data,
  output logic                     emr_cache_int,
  input  logic                     emr_cache_ack,
  output logic [LEVEL_W-1:0]       cache_fill_level,
  output logic                     cache_full,
  output logic                     overflow,
  output logic                     busy
);

  localparam int CNT_W = $clog2(emr_reg_width);
  localparam int PTR_W = $clog2(cache_depth);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(emr_reg_width - 1);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(cache_depth - 1);
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(cache_depth);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PUSH} state_t;

  state_t                   state, state_nxt;
  logic                     crcerror_q;
  logic                     pending;
  logic [CNT_W-1:0]         bit_cnt;
  logic [emr_reg_width-1:0] asm_word;

  logic [emr_reg_width-1:0] mem [cache_depth];
  logic [PTR_W-1:0]         rd_ptr, wr_ptr;
  logic [LEVEL_W-1:0]       level;

  logic crc_edge;
  logic edge_lost;
  logic dup;
  logic push_req, do_push, do_pop, push_drop;

  assign crc_edge = crcerror & ~crcerror_q;
  // A second request is already queued, so this one has nowhere to go.
  assign edge_lost = crc_edge & (state != IDLE) & pending;

`ifdef SEU_EMR_DUP_FILTER_EN
  logic [emr_reg_width-1:0] last_pushed;
  logic                     last_valid;

  assign dup = last_valid && (asm_word == last_pushed);
`else
  assign dup = 1'b0;
`endif

  assign push_req  = (state == PUSH) && !dup;
  assign do_pop    = emr_cache_ack && (level != '0);
  // A full cache still accepts the word when the head leaves in the same cycle.
  assign do_push   = push_req && (!cache_full || do_pop);
  assign push_drop = push_req && cache_full && !do_pop;

  always_comb begin
    state_nxt = state;
    shiftnld  = 1'b1;
    case (state)
      IDLE:  if (crc_edge || pending) state_nxt = LOAD;
      LOAD: begin
        shiftnld  = 1'b0;
        state_nxt = SHIFT;
      end
      SHIFT: if (bit_cnt == LAST_BIT) state_nxt = PUSH;
      PUSH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      crcerror_q <= 1'b0;
      pending    <= 1'b0;
      bit_cnt    <= '0;
      asm_word   <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      crcerror_q <= crcerror;
      overflow   <= overflow | edge_lost | push_drop;

      if (state == IDLE) begin
        // Servicing the queued request; an edge in this same cycle becomes
        // the new queued request.
        pending <= pending & crc_edge;
      end else if (crc_edge && !pending) begin
        pending <= 1'b1;
      end

      if (state == LOAD) begin
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt  <= bit_cnt + CNT_W'(1);
        // Right shift into the MSB: the first bit sampled lands in bit 0.
        asm_word <= {regout, asm_word[emr_reg_width-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < cache_depth; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= asm_word;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef SEU_EMR_DUP_FILTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pushed <= '0;
      last_valid  <= 1'b0;
    end else if (do_push) begin
      last_pushed <= asm_word;
      last_valid  <= 1'b1;
    end
  end
`endif

  assign emr_data         = mem[rd_ptr];
  assign emr_cache_int    = (level != '0);
  assign cache_fill_level = level;
  assign cache_full       = (level == FULL_LVL);
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_seu_emr_unloader.sv
// tb/tb_seu_emr_unloader.sv - randomized self-checking bench for seu_emr_unloader

module tb_seu_emr_unloader;

  localparam int W  = 46;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);
`ifdef SEU_EMR_DUP_FILTER_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          crcerror;
  logic          regout;
  logic          shiftnld;
  logic [W-1:0]  emr_data;
  logic          emr_cache_int;
  logic          emr_cache_ack;
  logic [LW-1:0] cache_fill_level;
  logic          cache_full;
  logic          overflow;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  seu_emr_unloader #(.emr_reg_width(W), .cache_depth(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .crcerror         (crcerror),
    .regout           (regout),
    .shiftnld         (shiftnld),
    .emr_data         (emr_data),
    .emr_cache_int    (emr_cache_int),
    .emr_cache_ack    (emr_cache_ack),
    .cache_fill_level (cache_fill_level),
    .cache_full       (cache_full),
    .overflow         (overflow),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Behavioural atom: loads its EMR when shiftnld is low, otherwise shifts
  // right, always presenting bit 0 on regout.
  logic [W-1:0] atom_sr;
  logic [W-1:0] atom_val;
  always @(posedge clk) begin
    if (!shiftnld) atom_sr <= atom_val;
    else           atom_sr <= atom_sr >> 1;
  end
  assign regout = atom_sr[0];

  // Reference model: the cache as a queue of captured words.
  logic [W-1:0] mq[$];
  bit           m_ovf;
  bit           m_lv;
  logic [W-1:0] m_last;

  function automatic void m_done(input logic [W-1:0] v);
    if (DUP_EN && m_lv && v == m_last) return;
    if (mq.size() >= D) m_ovf = 1'b1;
    else begin
      mq.push_back(v);
      m_last = v;
      m_lv   = 1'b1;
    end
  endfunction

  function automatic logic [W-1:0] rw();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, " level"}, 64'(cache_fill_level), 64'(mq.size()));
    chk({where, " int"},   64'(emr_cache_int),    64'(mq.size() != 0));
    chk({where, " full"},  64'(cache_full),       64'(mq.size() == D));
    chk({where, " ovf"},   64'(overflow),         64'(m_ovf));
    chk({where, " busy"},  64'(busy),             64'(0));
    if (mq.size() != 0) chk({where, " data"}, 64'(emr_data), 64'(mq[0]));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle wait", 64'(busy), 64'(0));
  endtask

  task automatic capture(input logic [W-1:0] v);
    @(negedge clk);
    atom_val = v;
    crcerror = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    crcerror = 1'b0;
    wait_idle();
    m_done(v);
  endtask

  task automatic ack_one();
    @(negedge clk);
    emr_cache_ack = 1'b1;
    @(negedge clk);
    emr_cache_ack = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    crcerror = 1'b0;
    emr_cache_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_lv  = 1'b0;
  endtask

  task automatic check_reset_vals(input string where);
    chk({where, " shiftnld"}, 64'(shiftnld),         64'(1));
    chk({where, " busy"},     64'(busy),             64'(0));
    chk({where, " int"},      64'(emr_cache_int),    64'(0));
    chk({where, " level"},    64'(cache_fill_level), 64'(0));
    chk({where, " full"},     64'(cache_full),       64'(0));
    chk({where, " ovf"},      64'(overflow),         64'(0));
    chk({where, " data"},     64'(emr_data),         64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat, v1, v2, v3, v4, prev;
    int lows, low_at, rise_at, busy_cnt, first_idle, busy_after;

    reset = 1'b1;
    crcerror = 1'b0;
    emr_cache_ack = 1'b0;
    atom_val = '0;
    m_ovf = 1'b0;
    m_lv = 1'b0;
    m_last = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // Single capture with latency and handshake timing.
    pat = 46'h2A5A5A5A5A5;
    lows = 0; low_at = 0; rise_at = 0; busy_cnt = 0;
    @(negedge clk);
    atom_val = pat;
    crcerror = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 3) crcerror = 1'b0;
      if (!shiftnld) begin
        lows++;
        if (low_at == 0) low_at = c;
      end
      if (busy) busy_cnt++;
      if (emr_cache_int && rise_at == 0) rise_at = c;
    end
    m_done(pat);
    chk("t1 load cycles", 64'(lows), 64'(1));
    chk("t1 load at", 64'(low_at), 64'(1));
    chk("t1 busy cycles", 64'(busy_cnt), 64'(W + 2));
    chk("t1 int latency", 64'(rise_at), 64'(W + 3));
    chk("t1 data", 64'(emr_data), 64'(pat));
    check_all("t1");

    // Fill past capacity without acks, then drain.
    do_reset();
    repeat (5) capture(rw());
    check_all("fill");
    for (int i = 0; i < 4; i++) begin
      ack_one();
      check_all("drain");
    end

    // Reset in the middle of a shift, then a clean capture.
    capture(rw());
    check_all("pre-rst");
    @(negedge clk);
    atom_val = rw();
    crcerror = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 2) crcerror = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_lv = 1'b0;
    capture(rw());
    check_all("post-rst");

    // Back-to-back: second edge during SHIFT is queued.
    do_reset();
    v1 = rw(); v2 = rw();
    first_idle = 0; busy_after = 0;
    @(negedge clk);
    atom_val = v1;
    crcerror = 1'b1;
    for (int c = 1; c <= 2 * (W + 2) + 6; c++) begin
      @(negedge clk);
      if (c == 2) crcerror = 1'b0;
      if (c == 10) begin crcerror = 1'b1; atom_val = v2; end
      if (c == 12) crcerror = 1'b0;
      if (first_idle != 0 && c == first_idle + 1) busy_after = int'(busy);
      if (!busy && first_idle == 0) first_idle = c;
    end
    wait_idle();
    m_done(v1);
    m_done(v2);
    chk("b2b first idle", 64'(first_idle), 64'(W + 3));
    chk("b2b relaunch", 64'(busy_after), 64'(1));
    check_all("b2b");

    // Third edge while a request is already queued is lost.
    do_reset();
    v3 = rw(); v4 = rw();
    @(negedge clk);
    atom_val = v3;
    crcerror = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2) crcerror = 1'b0;
      if (c == 10) begin crcerror = 1'b1; atom_val = v4; end
      if (c == 12) crcerror = 1'b0;
      if (c == 20) crcerror = 1'b1;
      if (c == 22) crcerror = 1'b0;
    end
    wait_idle();
    repeat (3) @(negedge clk);
    wait_idle();
    m_done(v3);
    m_done(v4);
    m_ovf = 1'b1;
    check_all("b2b3");

    // Full cache, ack during the PUSH cycle.
    do_reset();
    repeat (4) capture(rw());
    check_all("full4");
    v1 = rw();
    @(negedge clk);
    atom_val = v1;
    crcerror = 1'b1;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (c == 2) crcerror = 1'b0;
      if (c == W + 2) emr_cache_ack = 1'b1;
      if (c == W + 3) emr_cache_ack = 1'b0;
    end
    wait_idle();
    void'(mq.pop_front());
    mq.push_back(v1);
    check_all("pushack");

    // Ack on an empty cache must not move the pointers.
    do_reset();
    ack_one();
    ack_one();
    check_all("ackempty");
    capture(rw());
    check_all("ackempty cap");

    // Duplicate captures.
    do_reset();
    v1 = rw();
    v2 = v1 ^ 46'h1;
    capture(v1);
    capture(v1);
    capture(v2);
    chk("dup level", 64'(cache_fill_level), DUP_EN ? 64'(2) : 64'(3));
    check_all("dup");

    // Randomized captures and acks.
    do_reset();
    prev = rw();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 5) begin
        v1 = ($urandom_range(0, 3) == 0) ? prev : rw();
        prev = v1;
        capture(v1);
      end else begin
        ack_one();
      end
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
